// File: rtl/speed_tick_gen.sv
// speed_tick_gen: geometric-rate tick generator with run-time level select and pause
// Optional feature macro: SPEED_SQUARE_OUT_EN (per-level square-wave outputs on speed)
// Ports:
//   clk    in   system clock, all state on rising edge
//   reset  in   synchronous active-high reset
//   up     in   one-cycle request: one level faster (saturates at 0)
//   down   in   one-cycle request: one level slower (saturates at LEVELS-1)
//   pause  in   level-sensitive freeze of all counters; tick forced low
//   level  out  current level
//   tick   out  registered one-cycle strobe at the selected level's rate
//   speed  out  per-level 50% square waves, or all zero without the macro
module speed_tick_gen #(
    parameter int BASE_DIV = 50,
    parameter int RATIO = 2,
    parameter int LEVELS = 4,
    parameter int INIT_LEVEL = 0,
    localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up,
    input  logic              down,
    input  logic              pause,
    output logic [LW-1:0]     level,
    output logic              tick,
    output logic [LEVELS-1:0] speed
);
    localparam int PW = $clog2(BASE_DIV);
    localparam int CW = $clog2(RATIO);

    logic [PW-1:0]     pre;
    logic [LEVELS-1:0] stb;
    logic [LW-1:0]     level_nx;

    assign stb[0] = (pre == PW'(BASE_DIV - 1)) && !pause;

    always_ff @(posedge clk) begin
        if (reset)
            pre <= '0;
        else if (!pause)
            pre <= stb[0] ? '0 : pre + PW'(1);
    end

    // Each stage divides the previous stage's strobe by RATIO; the whole chain
    // free-runs regardless of level, so switching levels stays phase-coherent.
    genvar k;
    for (k = 1; k < LEVELS; k++) begin : g_stage
        logic [CW-1:0] c;
        assign stb[k] = stb[k-1] && (c == CW'(RATIO - 1));
        always_ff @(posedge clk) begin
            if (reset)
                c <= '0;
            else if (stb[k-1])
                c <= (c == CW'(RATIO - 1)) ? '0 : c + CW'(1);
        end
    end

    always_comb begin
        level_nx = (up && !down && level != '0) ? level - LW'(1) :
                   (down && !up && level != LW'(LEVELS - 1)) ? level + LW'(1) : level;
    end

    // tick selects with the level being loaded on this same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= LW'(INIT_LEVEL);
            tick  <= 1'b0;
        end else begin
            level <= level_nx;
            tick  <= stb[level_nx];
        end
    end

`ifdef SPEED_SQUARE_OUT_EN
    always_ff @(posedge clk) begin
        if (reset)
            speed <= '0;
        else
            speed <= speed ^ stb;
    end
`else
    assign speed = '0;
`endif
endmodule

// File: tb/tb_speed_tick_gen.sv
// tb_speed_tick_gen: randomized and directed checks of speed_tick_gen against an arithmetic model
module tb_speed_tick_gen;
    localparam int BD = 4;
    localparam int RT = 2;
    localparam int LV = 4;
    localparam int IL = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] level;
    logic       tick;
    logic [3:0] speed;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n = 0;
    int mlevel = IL;
    bit mtick = 1'b0;

    speed_tick_gen #(.BASE_DIV(BD), .RATIO(RT), .LEVELS(LV), .INIT_LEVEL(IL)) dut (
        .clk(clk), .reset(reset), .up(up), .down(down), .pause(pause),
        .level(level), .tick(tick), .speed(speed)
    );

    always #5 clk = ~clk;

    function automatic int period(input int k);
        return BD * (RT ** k);
    endfunction

    // square wave k toggles each time n crosses a multiple of its tick period
    function automatic logic [3:0] exp_speed();
        logic [3:0] s;
        s = '0;
`ifdef SPEED_SQUARE_OUT_EN
        for (int k = 0; k < LV; k++) s[k] = ((n / period(k)) % 2) == 1;
`endif
        return s;
    endfunction

    // model: n counts unpaused edges since reset; the level-L tick fires when n hits a multiple of its period
    task automatic step(input bit r, input bit u, input bit d, input bit p);
        reset = r; up = u; down = d; pause = p;
        @(posedge clk);
        cyc++;
        if (r) begin
            n = 0; mlevel = IL; mtick = 1'b0;
        end else begin
            if (u && !d && mlevel > 0) mlevel--;
            else if (d && !u && mlevel < LV - 1) mlevel++;
            if (!p) begin
                n++;
                mtick = (n % period(mlevel)) == 0;
            end else mtick = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            checks++;
            if (level !== 2'd0 || tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold level=%0d tick=%0b expected level=0 tick=0", level, tick);
            end
        end
        for (int e = 1; e <= 13; e++) begin
            step(0, 0, 0, 0);
            checks++;
            if (tick !== ((e % 4) == 0)) begin
                errors++;
                $display("FAIL reset_release_tick edge=%0d tick=%0b expected %0b", e, tick, (e % 4) == 0);
            end
        end
    endtask

    task automatic test_level_down();
        int last = -1;
        int last_i = -1;
        for (int i = 0; i < 64; i++) begin
            step(0, 0, (i == 0 || i == 2), 0);
            if (i == 2) begin
                checks++;
                if (level !== 2'd2) begin
                    errors++;
                    $display("FAIL down_level level=%0d expected 2", level);
                end
            end
            checks++;
            if (tick !== mtick) begin
                errors++;
                $display("FAIL down_tick i=%0d tick=%0b expected %0b", i, tick, mtick);
            end
            if (tick === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last < 4) begin
                        errors++;
                        $display("FAIL down_min_gap gap=%0d expected >=4", cyc - last);
                    end
                    if (last_i > 2) begin
                        checks++;
                        if (cyc - last != 16) begin
                            errors++;
                            $display("FAIL down_period gap=%0d expected 16", cyc - last);
                        end
                    end
                end
                last = cyc;
                last_i = i;
            end
        end
    endtask

    task automatic test_saturation();
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        checks++;
        if (level !== 2'd3) begin
            errors++;
            $display("FAIL sat_high level=%0d expected 3", level);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        checks++;
        if (level !== 2'd0) begin
            errors++;
            $display("FAIL sat_low level=%0d expected 0", level);
        end
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        checks++;
        if (level !== 2'd1) begin
            errors++;
            $display("FAIL up_down_collide level=%0d expected 1", level);
        end
        checks++;
        if (tick !== mtick) begin
            errors++;
            $display("FAIL sat_tick tick=%0b expected %0b", tick, mtick);
        end
    endtask

    task automatic test_pause();
        int found = -1;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1);
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_tick i=%0d tick=%0b expected 0", i, tick);
            end
        end
        for (int e = 13; e <= 30 && found < 0; e++) begin
            step(0, 0, 0, 0);
            if (tick === 1'b1) found = e;
        end
        checks++;
        if (found != 14) begin
            errors++;
            $display("FAIL pause_resume first_tick_edge=%0d expected 14", found);
        end
    endtask

    task automatic test_reset_mid();
        int found = -1;
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        checks++;
        if (level !== 2'd2) begin
            errors++;
            $display("FAIL mid_pre_level level=%0d expected 2", level);
        end
        step(1, 0, 1, 0);
        checks++;
        if (level !== 2'd0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset level=%0d tick=%0b expected level=0 tick=0", level, tick);
        end
        for (int e = 1; e <= 10 && found < 0; e++) begin
            step(0, 0, 0, 0);
            if (tick === 1'b1) found = e;
        end
        checks++;
        if (found != 4) begin
            errors++;
            $display("FAIL mid_first_tick edge=%0d expected 4", found);
        end
    endtask

    task automatic test_speed();
        logic [3:0] exp;
        step(1, 0, 0, 0);
        for (int e = 1; e <= 40; e++) begin
            step(0, 0, 0, 0);
            exp = '0;
`ifdef SPEED_SQUARE_OUT_EN
            for (int k = 0; k < LV; k++) exp[k] = ((e / (4 << k)) % 2) == 1;
`endif
            checks++;
            if (speed !== exp) begin
                errors++;
                $display("FAIL speed_wave edge=%0d speed=%b expected %b", e, speed, exp);
            end
        end
    endtask

    task automatic test_random();
        bit r, u, d, p;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 49) == 0;
            u = $urandom_range(0, 7) == 0;
            d = $urandom_range(0, 6) == 0;
            p = $urandom_range(0, 5) == 0;
            step(r, u, d, p);
            checks++;
            if (level !== 2'(mlevel) || tick !== mtick || speed !== exp_speed()) begin
                errors++;
                $display("FAIL random i=%0d level=%0d tick=%0b speed=%b expected level=%0d tick=%0b speed=%b",
                         i, level, tick, speed, mlevel, mtick, exp_speed());
            end
        end
    endtask

    initial begin
        test_reset();
        test_level_down();
        test_saturation();
        test_pause();
        test_reset_mid();
        test_speed();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/speed_tick_gen.md
# speed_tick_gen

Parametrised speed-rate generator for the game/display logic. It derives LEVELS geometric rates from the system clock through one synchronous prescaler and a chain of ratio counters; no derived clocks are used. It emits a single-cycle `tick` strobe at the currently selected rate. The rate is stepped faster or slower at run time by one-cycle `up`/`down` requests, and the whole generator can be frozen with `pause`. Consumers use `tick` as a clock enable in the `clk` domain.

## Interface
- BASE_DIV, 50: `clk` cycles per level-0 period; must be ≥2.
- RATIO, 2: period multiplier between adjacent levels; must be ≥2.
- LEVELS, 4: number of selectable levels; must be ≥1. Level 0 is fastest.
- INIT_LEVEL, 0: level loaded on reset; must be < LEVELS.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- up  in  1  one-cycle request: move one level faster (level−1).
- down  in  1  one-cycle request: move one level slower (level+1).
- pause  in  1  level-sensitive; while high, all counters hold and `tick` is 0.
- level  out  LW  current level, where LW = max(1, $clog2(LEVELS)).
- tick  out  1  registered one-cycle strobe at the selected rate.
- speed  out  LEVELS  per-level square waves; see Configuration.

## Operation
- Prescaler `pre`, width $clog2(BASE_DIV):
  - Counts 0..BASE_DIV−1 while `pause`=0, then wraps to 0.
  - Internal strobe stb[0] = (pre==BASE_DIV−1) && !pause.
- Stage counters c[k], k = 1..LEVELS−1, width $clog2(RATIO):
  - c[k] advances only on stb[k−1], counting 0..RATIO−1 and wrapping.
  - stb[k] = stb[k−1] && (c[k]==RATIO−1).
  - Level k period is therefore BASE_DIV·RATIO^k cycles.
- `tick` register: loads stb[level] on every edge.
- Level control, evaluated on each edge:
  - `up` alone: level−1, saturating at 0.
  - `down` alone: level+1, saturating at LEVELS−1.
  - `up` and `down` together, or neither: no change.
  - `up`/`down` are honoured even while `pause`=1.
- A level change does not clear any counter. The new rate stays phase-coherent with the free-running chain, and no extra or short tick is produced.
- Reset (synchronous, any time, including mid-count):
  - `pre`, every c[k], `tick`, and every `speed` bit become 0.
  - `level` becomes INIT_LEVEL.
  - `up`, `down` and `pause` are ignored on the reset edge.

## Timing
- Reference point: edge 1 is the first rising edge with `reset`=0, and `pause`=0 throughout.
  - `pre` reaches BASE_DIV−1 after edge BASE_DIV−1.
  - `tick` is high for exactly one cycle after edge BASE_DIV when level=0.
  - `tick` then repeats every BASE_DIV edges.
- Level k: first `tick` after edge BASE_DIV·RATIO^k, then periodic at the same interval.
- Latency from stb[level] to `tick`: one cycle, registered.
- `level` updates on the edge that samples `up`/`down`. `tick` selects with the new level from that edge onward.
- Pause: when `pause` rises, the edge that samples it freezes all counters. A `tick` already registered on that edge is the last one. Counting resumes from the held values on the first edge with `pause`=0, so the period is extended by exactly the paused cycles.

## Configuration
- SPEED_SQUARE_OUT_EN defined:
  - Each speed[k] is a register that toggles on stb[k], giving a 50% duty square wave with period 2·BASE_DIV·RATIO^k cycles.
  - The bits reset to 0 and freeze with `pause`.
- SPEED_SQUARE_OUT_EN not defined:
  - `speed` is tied to 0 and no toggle registers are built.
  - The port is always present.

## Test plan
Bench parameters: BASE_DIV=4, RATIO=2, LEVELS=4, INIT_LEVEL=0.
- Reset held 3 cycles, then released → `level`=0 and `tick`=0 during reset; `tick` high after edges 4, 8, 12; low on all other cycles.
- Two `down` pulses on separate cycles → `level`=2; consecutive ticks 16 cycles apart; no tick spacing shorter than 4 cycles around each change.
- Saturation and collisions:
  - At level 3, `down` → `level` stays 3.
  - At level 0, `up` → `level` stays 0.
  - `up` and `down` asserted in the same cycle at level 1 → `level` stays 1.
- `pause` held 10 cycles mid-period at level 0 → no tick while paused; the next tick arrives exactly 10 cycles later than unpaused.
- Reset asserted when `pre`=2, with level changed to 2 beforehand → next edge: `tick`=0 and `level`=0; first tick after edge 4 of the new release.
- With SPEED_SQUARE_OUT_EN:
  - speed[0] period is 8 cycles; speed[1] period is 16 cycles; all 50% duty.
  - Without the macro, `speed`=0 throughout.
